// File: rtl/prco_debug_stepper_if.sv
// Core-facing step handshake: mode/step towards prco_core, debug byte and
// instruction-completion strobe back from it.
interface prco_debug_stepper_if;
  localparam int unsigned DBG_W = 8;

  logic             q_mode;
  logic             q_step;
  logic [DBG_W-1:0] i_debug;
  logic             i_debug_instr_clk;

  modport master (
    output q_mode,
    output q_step,
    input  i_debug,
    input  i_debug_instr_clk
  );

  modport slave (
    input  q_mode,
    input  q_step,
    output i_debug,
    output i_debug_instr_clk
  );
endinterface

// File: rtl/prco_debug_stepper.sv
// Front-panel single-step controller for prco_core: debounced button issues one
// step per press, completion strobes latch and count the core debug byte.
module prco_debug_stepper #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned TIMEOUT_CYCLES  = 64
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_en,
  input  logic                  i_btn,
  input  logic                  i_run_sw,
  prco_debug_stepper_if.master  core,
  output logic                  q_busy,
  output logic [7:0]            q_last_debug,
  output logic [15:0]           q_step_count,
  output logic                  q_timeout
);
  localparam int unsigned DB_W  = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES);
  localparam int unsigned DBG_W = 8;
  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {S_IDLE, S_STEP, S_WAIT, S_RELEASE} state_t;

  state_t            state, next_state;
  logic              btn_meta, btn_s, run_meta, run_s;
  logic [1:0]        settle;
  logic [DB_W-1:0]   db_cnt;
  logic              btn_db, btn_db_d, press_q, armed;
  logic              dclk_r, dclk_r2, comp_q;
  logic [DBG_W-1:0]  dbg_r, dbg_q;
  logic [TO_W-1:0]   to_cnt;
  logic              mode_q, step_q;
  logic              mode_nxt, step_nxt, busy_nxt, capture, to_set, to_clr;

  assign core.q_mode = mode_q;
  assign core.q_step = step_q;

  // Two-flop synchronizers; settle marks when btn_s reflects the real pin.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      btn_meta <= 1'b0;
      btn_s    <= 1'b0;
      run_meta <= 1'b0;
      run_s    <= 1'b0;
      settle   <= 2'b00;
    end else begin
      btn_meta <= i_btn;
      btn_s    <= btn_meta;
      run_meta <= i_run_sw;
      run_s    <= run_meta;
      settle   <= {settle[0], 1'b1};
    end
  end

  // Debouncer and press detect; armed blocks a button held through reset.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      db_cnt   <= '0;
      btn_db   <= 1'b0;
      btn_db_d <= 1'b0;
      press_q  <= 1'b0;
      armed    <= 1'b0;
    end else begin
      if (btn_s != btn_db) begin
        if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          btn_db <= btn_s;
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + DB_W'(1);
        end
      end else begin
        db_cnt <= '0;
      end
      btn_db_d <= btn_db;
      press_q  <= armed & btn_db & ~btn_db_d;
      if (settle[1] && !btn_s) armed <= 1'b1;
    end
  end

  // Completion edge detect, debug byte pipelined alongside it.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      dclk_r  <= 1'b0;
      dclk_r2 <= 1'b0;
      comp_q  <= 1'b0;
      dbg_r   <= '0;
      dbg_q   <= '0;
    end else begin
      dclk_r  <= core.i_debug_instr_clk;
      dclk_r2 <= dclk_r;
      comp_q  <= dclk_r & ~dclk_r2;
      dbg_r   <= core.i_debug;
      dbg_q   <= dbg_r;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) state <= S_IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:    if (mode_q && i_en && press_q) next_state = S_STEP;
      S_STEP:    next_state = S_WAIT;
      S_WAIT:    if (comp_q || (to_cnt == TO_W'(TIMEOUT_CYCLES - 1))) next_state = S_RELEASE;
      S_RELEASE: if (!btn_db) next_state = S_IDLE;
      default:   next_state = S_IDLE;
    endcase
  end

  // Completion beats timeout in WAIT; run-mode completions count from IDLE.
  always_comb begin
    step_nxt = 1'b0;
    busy_nxt = 1'b0;
    mode_nxt = mode_q;
    capture  = 1'b0;
    to_set   = 1'b0;
    to_clr   = 1'b0;
    step_nxt = (next_state == S_STEP);
    busy_nxt = (next_state != S_IDLE);
    case (state)
      S_IDLE: begin
        mode_nxt = ~run_s;
        capture  = comp_q & ~mode_q;
        to_clr   = (next_state == S_STEP);
      end
      S_WAIT: begin
        capture = comp_q;
        to_set  = ~comp_q & (next_state == S_RELEASE);
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      mode_q       <= 1'b1;
      step_q       <= 1'b0;
      q_busy       <= 1'b0;
      q_last_debug <= '0;
      q_step_count <= '0;
      q_timeout    <= 1'b0;
      to_cnt       <= '0;
    end else begin
      mode_q <= mode_nxt;
      step_q <= step_nxt;
      q_busy <= busy_nxt;
      if (capture) begin
        q_last_debug <= dbg_q;
        q_step_count <= q_step_count + CNT_W'(1);
      end
      if (to_clr)      q_timeout <= 1'b0;
      else if (to_set) q_timeout <= 1'b1;
      if (state == S_STEP)      to_cnt <= '0;
      else if (state == S_WAIT) to_cnt <= to_cnt + TO_W'(1);
    end
  end
endmodule

// File: tb/tb_prco_debug_stepper.sv
// Bench for prco_debug_stepper: randomized presses, bounces, timeouts and
// run-mode completions against a transaction-level expectation model.
module tb_prco_debug_stepper;
  localparam int unsigned DB = 16;
  localparam int unsigned TO = 64;

  logic        clk = 1'b0;
  logic        rst_n, en, btn, run_sw;
  logic        busy, timeout;
  logic [7:0]  last_dbg;
  logic [15:0] step_cnt;

  prco_debug_stepper_if core();

  prco_debug_stepper #(.DEBOUNCE_CYCLES(DB), .TIMEOUT_CYCLES(TO)) dut (
    .i_clk       (clk),
    .i_reset     (rst_n),
    .i_en        (en),
    .i_btn       (btn),
    .i_run_sw    (run_sw),
    .core        (core),
    .q_busy      (busy),
    .q_last_debug(last_dbg),
    .q_step_count(step_cnt),
    .q_timeout   (timeout)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int step_pulses = 0;
  logic [15:0] exp_count = 16'h0000;
  logic [7:0]  exp_last = 8'h00;

  always @(negedge clk) if (core.q_step === 1'b1) step_pulses++;

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_step(output int lat, output bit ok);
    lat = -1; ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      tick(1);
      if (core.q_step === 1'b1) begin lat = k; ok = 1'b1; return; end
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      tick(1);
      if (busy === 1'b0) begin ok = 1'b1; return; end
    end
  endtask

  task automatic complete(input logic [7:0] d);
    core.i_debug = d;
    core.i_debug_instr_clk = 1'b1;
    tick(1);
    core.i_debug_instr_clk = 1'b0;
    tick(1);
  endtask

  task automatic press_and_complete(input logic [7:0] d, input int delay, input bit drop_en);
    int base, lat; bit ok;
    base = step_pulses;
    btn = 1'b1;
    wait_step(lat, ok);
    total++; if (!ok || lat != int'(DB) + 3) begin bad++; $display("FAIL press_latency: got %0d want %0d", lat, DB + 3); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL busy_with_step: got %b want 1", busy); end
    total++; if (timeout !== 1'b0) begin bad++; $display("FAIL timeout_cleared: got %b want 0", timeout); end
    if (drop_en) en = 1'b0;
    tick(delay);
    core.i_debug = d;
    core.i_debug_instr_clk = 1'b1;
    tick(1);
    core.i_debug_instr_clk = 1'b0;
    tick(1);
    total++; if (step_cnt !== exp_count) begin bad++; $display("FAIL count_early: got %0h want %0h", step_cnt, exp_count); end
    tick(1);
    exp_count = exp_count + 16'd1;
    exp_last = d;
    total++; if (step_cnt !== exp_count) begin bad++; $display("FAIL step_count: got %0h want %0h", step_cnt, exp_count); end
    total++; if (last_dbg !== exp_last) begin bad++; $display("FAIL last_debug: got %0h want %0h", last_dbg, exp_last); end
    tick(10);
    btn = 1'b0;
    wait_idle(ok);
    total++; if (!ok) begin bad++; $display("FAIL busy_release: got busy=%b want 0", busy); end
    en = 1'b1;
    total++; if (step_pulses - base != 1) begin bad++; $display("FAIL step_pulses: got %0d want 1", step_pulses - base); end
    tick(5);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; btn = 1'b0; run_sw = 1'b0;
    core.i_debug = 8'h00; core.i_debug_instr_clk = 1'b0;
    tick(3);
    total++; if (core.q_mode !== 1'b1) begin bad++; $display("FAIL rst_mode: got %b want 1", core.q_mode); end
    total++; if (core.q_step !== 1'b0) begin bad++; $display("FAIL rst_step: got %b want 0", core.q_step); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    total++; if (last_dbg !== 8'h00) begin bad++; $display("FAIL rst_last: got %0h want 0", last_dbg); end
    total++; if (step_cnt !== 16'h0000) begin bad++; $display("FAIL rst_count: got %0h want 0", step_cnt); end
    total++; if (timeout !== 1'b0) begin bad++; $display("FAIL rst_timeout: got %b want 0", timeout); end
    rst_n = 1'b1;
    tick(5);
  endtask

  task automatic test_clean_press();
    press_and_complete(8'hA5, 3, 1'b0);
  endtask

  task automatic test_bounce();
    int base;
    base = step_pulses;
    for (int i = 0; i < 5; i++) begin
      btn = 1'b1; tick(int'($urandom_range(2, 5)));
      btn = 1'b0; tick(int'($urandom_range(2, 5)));
    end
    press_and_complete(8'($urandom), int'($urandom_range(1, 10)), 1'b0);
    total++; if (step_pulses - base != 1) begin bad++; $display("FAIL bounce_pulses: got %0d want 1", step_pulses - base); end
  endtask

  task automatic test_timeout();
    int base, lat, k; bit ok;
    base = step_pulses;
    btn = 1'b1;
    wait_step(lat, ok);
    total++; if (!ok) begin bad++; $display("FAIL to_step: got none want pulse"); end
    btn = 1'b0;
    k = -1;
    for (int i = 0; i < 200; i++) begin
      tick(1);
      if (timeout === 1'b1) begin k = i; break; end
    end
    total++; if (k != int'(TO)) begin bad++; $display("FAIL timeout_latency: got %0d want %0d", k, TO); end
    wait_idle(ok);
    tick(5);
    total++; if (timeout !== 1'b1) begin bad++; $display("FAIL timeout_sticky: got %b want 1", timeout); end
    total++; if (step_cnt !== exp_count) begin bad++; $display("FAIL timeout_count: got %0h want %0h", step_cnt, exp_count); end
    total++; if (last_dbg !== exp_last) begin bad++; $display("FAIL timeout_last: got %0h want %0h", last_dbg, exp_last); end
    total++; if (step_pulses - base != 1) begin bad++; $display("FAIL timeout_pulses: got %0d want 1", step_pulses - base); end
    press_and_complete(8'($urandom), 2, 1'b0);
  endtask

  task automatic test_back_to_back();
    int base, lat; bit ok;
    logic [7:0] d;
    base = step_pulses;
    d = 8'($urandom);
    btn = 1'b1;
    wait_step(lat, ok);
    btn = 1'b0; tick(20);
    btn = 1'b1; tick(25);
    complete(d);
    tick(2);
    exp_count = exp_count + 16'd1;
    exp_last = d;
    btn = 1'b0;
    wait_idle(ok);
    tick(30);
    total++; if (step_pulses - base != 1) begin bad++; $display("FAIL b2b_pulses: got %0d want 1", step_pulses - base); end
    total++; if (step_cnt !== exp_count) begin bad++; $display("FAIL b2b_count: got %0h want %0h", step_cnt, exp_count); end
    total++; if (last_dbg !== exp_last) begin bad++; $display("FAIL b2b_last: got %0h want %0h", last_dbg, exp_last); end
  endtask

  task automatic test_enable();
    int base;
    base = step_pulses;
    en = 1'b0; btn = 1'b1; tick(40);
    en = 1'b1; tick(10);
    btn = 1'b0; tick(30);
    total++; if (step_pulses - base != 0) begin bad++; $display("FAIL en_pulses: got %0d want 0", step_pulses - base); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL en_busy: got %b want 0", busy); end
  endtask

  task automatic test_random_steps();
    for (int i = 0; i < 4; i++)
      press_and_complete(8'($urandom), int'($urandom_range(1, 10)), 1'($urandom_range(0, 1)));
  endtask

  task automatic test_run_mode();
    int base;
    base = step_pulses;
    run_sw = 1'b1; tick(4);
    total++; if (core.q_mode !== 1'b0) begin bad++; $display("FAIL run_mode: got %b want 0", core.q_mode); end
    for (int i = 0; i < 10; i++) begin
      btn = 1'($urandom_range(0, 1));
      complete(8'(i));
      exp_count = exp_count + 16'd1;
      exp_last = 8'(i);
    end
    tick(3);
    total++; if (step_cnt !== exp_count) begin bad++; $display("FAIL run_count: got %0h want %0h", step_cnt, exp_count); end
    total++; if (last_dbg !== 8'h09) begin bad++; $display("FAIL run_last: got %0h want 09", last_dbg); end
    total++; if (step_pulses - base != 0) begin bad++; $display("FAIL run_pulses: got %0d want 0", step_pulses - base); end
    btn = 1'b0; run_sw = 1'b0; tick(4);
    total++; if (core.q_mode !== 1'b1) begin bad++; $display("FAIL step_mode: got %b want 1", core.q_mode); end
    tick(30);
  endtask

  task automatic test_wrap();
    int n;
    logic [7:0] d;
    run_sw = 1'b1; tick(4);
    n = 65536 - int'(exp_count);
    for (int i = 0; i < n - 1; i++) begin
      d = 8'($urandom);
      complete(d);
      exp_count = exp_count + 16'd1;
      exp_last = d;
    end
    tick(2);
    total++; if (step_cnt !== 16'hFFFF) begin bad++; $display("FAIL wrap_max: got %0h want ffff", step_cnt); end
    d = 8'($urandom);
    complete(d);
    exp_count = exp_count + 16'd1;
    exp_last = d;
    tick(2);
    total++; if (step_cnt !== 16'h0000) begin bad++; $display("FAIL wrap_zero: got %0h want 0", step_cnt); end
    total++; if (last_dbg !== exp_last) begin bad++; $display("FAIL wrap_last: got %0h want %0h", last_dbg, exp_last); end
    run_sw = 1'b0; tick(10);
  endtask

  task automatic test_reset_mid_step();
    int base, lat; bit ok;
    btn = 1'b1;
    wait_step(lat, ok);
    tick(3);
    #2 rst_n = 1'b0;
    #1;
    total++; if (core.q_mode !== 1'b1) begin bad++; $display("FAIL mid_rst_mode: got %b want 1", core.q_mode); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
    total++; if (step_cnt !== 16'h0000) begin bad++; $display("FAIL mid_rst_count: got %0h want 0", step_cnt); end
    total++; if (last_dbg !== 8'h00) begin bad++; $display("FAIL mid_rst_last: got %0h want 0", last_dbg); end
    total++; if (timeout !== 1'b0 || core.q_step !== 1'b0) begin bad++; $display("FAIL mid_rst_flags: got to=%b step=%b want 0 0", timeout, core.q_step); end
    exp_count = 16'h0000;
    exp_last = 8'h00;
    tick(2);
    rst_n = 1'b1;
    base = step_pulses;
    tick(60);
    total++; if (step_pulses - base != 0) begin bad++; $display("FAIL held_btn_pulses: got %0d want 0", step_pulses - base); end
    btn = 1'b0; tick(30);
    press_and_complete(8'($urandom), int'($urandom_range(1, 10)), 1'b0);
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_timeout();
    test_back_to_back();
    test_enable();
    test_random_steps();
    test_run_mode();
    test_wrap();
    test_reset_mid_step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
